// File: rtl/pi_out_limiter_pkg.sv
// Shared definitions for the PI output limiter: state encoding,
// datapath width and signed saturation/clamp helpers.
package pi_out_limiter_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOFT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic signed [W-1:0] sat32(
        input logic signed [W:0] x
    );
        if (x[W] != x[W-1]) begin
            return x[W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
        return x[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] clamp32(
        input logic signed [W-1:0] x,
        input logic signed [W-1:0] lo,
        input logic signed [W-1:0] hi
    );
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/pi_out_limiter_ss_ramp.sv
// Soft-start ceiling generator: raises the command ceiling by a fixed
// step every SS_DIV enabled cycles until it reaches OUT_MAX.
module pi_out_limiter_ss_ramp
    import pi_out_limiter_pkg::*;
#(
    parameter int OUT_MIN = 0,
    parameter int OUT_MAX = 1000,
    parameter int SS_STEP = 10,
    parameter int SS_DIV  = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                restart_i,
    output logic signed [W-1:0] ceil_o,
    output logic                done_o
);

    localparam logic signed [W:0] MAX33 = (W+1)'(OUT_MAX);

    logic signed [W-1:0] ceil_q, ceil_d;
    logic [W-1:0]        div_q, div_d;
    logic signed [W:0]   sum;

    always_comb begin
        ceil_d = ceil_q;
        div_d  = div_q;
        // 33-bit sum so a step near the top of the range cannot wrap
        sum    = {ceil_q[W-1], ceil_q} + (W+1)'(SS_STEP);
        if (restart_i) begin
            ceil_d = OUT_MIN;
            div_d  = '0;
        end else if (en_i) begin
            if (div_q == W'(SS_DIV - 1)) begin
                div_d  = '0;
                ceil_d = (sum >= MAX33) ? OUT_MAX : sum[W-1:0];
            end else begin
                div_d = div_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ceil_q <= OUT_MIN;
            div_q  <= '0;
        end else begin
            ceil_q <= ceil_d;
            div_q  <= div_d;
        end
    end

    assign ceil_o = ceil_q;
    assign done_o = (ceil_q == OUT_MAX);

endmodule

// File: rtl/pi_out_limiter.sv
// PI output conditioning: clamp to a soft-start ceiling, rate-limit,
// and return the saturation excess as the anti-windup term.
module pi_out_limiter
    import pi_out_limiter_pkg::*;
#(
    parameter int OUT_MIN  = 0,
    parameter int OUT_MAX  = 1000,
    parameter int RATE_MAX = 50,
    parameter int SS_STEP  = 10,
    parameter int SS_DIV   = 4
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_EN,
    input  logic signed [W-1:0] i_PI,
    input  logic                i_VALID,
    output logic signed [W-1:0] o_CMD,
    output logic signed [W-1:0] o_AW,
    output logic                o_VALID,
    output logic                o_SAT,
    output logic [1:0]          o_STATE
);

    localparam logic signed [W:0] RATE = (W+1)'(RATE_MAX);

    state_t state_q, state_d;

    logic signed [W-1:0] ceil;
    logic                ramp_done;

    logic                s1_vld_q, s1_vld_d;
    logic signed [W-1:0] s1_c_q, s1_c_d;
    logic signed [W-1:0] s1_pi_q, s1_pi_d;

    logic signed [W-1:0] cmd_q, cmd_d;
    logic signed [W-1:0] aw_q, aw_d;
    logic                sat_q, sat_d;
    logic                vld_q, vld_d;

    logic signed [W:0]   diff, lim, aw_ext;
    logic signed [W-1:0] new_cmd, aw_sat;

    pi_out_limiter_ss_ramp #(
        .OUT_MIN (OUT_MIN),
        .OUT_MAX (OUT_MAX),
        .SS_STEP (SS_STEP),
        .SS_DIV  (SS_DIV)
    ) u_ss_ramp (
        .clk_i     (i_CLK),
        .rst_i     (i_RST),
        .en_i      (state_q == ST_SOFT),
        .restart_i (!i_EN || state_q == ST_IDLE),
        .ceil_o    (ceil),
        .done_o    (ramp_done)
    );

    always_comb begin
        state_d = state_q;
        if (!i_EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SOFT;
                ST_SOFT: if (ramp_done) state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s1_vld_d = 1'b0;
        s1_c_d   = s1_c_q;
        s1_pi_d  = s1_pi_q;
        cmd_d    = cmd_q;
        aw_d     = aw_q;
        sat_d    = sat_q;
        vld_d    = 1'b0;

        diff    = {s1_c_q[W-1], s1_c_q} - {cmd_q[W-1], cmd_q};
        lim     = (diff > RATE)  ? RATE :
                  (diff < -RATE) ? -RATE : diff;
        new_cmd = cmd_q + lim[W-1:0];
        aw_ext  = {s1_pi_q[W-1], s1_pi_q} - {new_cmd[W-1], new_cmd};
        aw_sat  = sat32(aw_ext);

        // EN low flushes both stages and snaps outputs to idle values
        if (!i_EN || state_q == ST_IDLE) begin
            cmd_d = OUT_MIN;
            aw_d  = '0;
            sat_d = 1'b0;
        end else begin
            if (i_VALID) begin
                s1_vld_d = 1'b1;
                s1_c_d   = clamp32(i_PI, OUT_MIN, ceil);
                s1_pi_d  = i_PI;
            end
            if (s1_vld_q) begin
                cmd_d = new_cmd;
                aw_d  = aw_sat;
                sat_d = (aw_sat != '0);
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= ST_IDLE;
            s1_vld_q <= 1'b0;
            s1_c_q   <= '0;
            s1_pi_q  <= '0;
            cmd_q    <= OUT_MIN;
            aw_q     <= '0;
            sat_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            s1_c_q   <= s1_c_d;
            s1_pi_q  <= s1_pi_d;
            cmd_q    <= cmd_d;
            aw_q     <= aw_d;
            sat_q    <= sat_d;
            vld_q    <= vld_d;
        end
    end

    assign o_CMD   = cmd_q;
    assign o_AW    = aw_q;
    assign o_SAT   = sat_q;
    assign o_VALID = vld_q;
    assign o_STATE = state_q;

endmodule

// File: tb/tb_pi_out_limiter.sv
// Randomized bench for pi_out_limiter with a cycle-level reference model
// and a few hand-computed scenario checks.
module tb_pi_out_limiter;

    localparam int OUT_MIN  = 0;
    localparam int OUT_MAX  = 1000;
    localparam int RATE_MAX = 50;
    localparam int SS_STEP  = 10;
    localparam int SS_DIV   = 4;

    logic               i_CLK = 1'b0;
    logic               i_RST;
    logic               i_EN;
    logic signed [31:0] i_PI;
    logic               i_VALID;
    logic signed [31:0] o_CMD;
    logic signed [31:0] o_AW;
    logic               o_VALID;
    logic               o_SAT;
    logic [1:0]         o_STATE;

    int errs = 0;
    int nchk = 0;

    pi_out_limiter #(
        .OUT_MIN  (OUT_MIN),
        .OUT_MAX  (OUT_MAX),
        .RATE_MAX (RATE_MAX),
        .SS_STEP  (SS_STEP),
        .SS_DIV   (SS_DIV)
    ) dut (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_EN    (i_EN),
        .i_PI    (i_PI),
        .i_VALID (i_VALID),
        .o_CMD   (o_CMD),
        .o_AW    (o_AW),
        .o_VALID (o_VALID),
        .o_SAT   (o_SAT),
        .o_STATE (o_STATE)
    );

    always #5 i_CLK = ~i_CLK;

    // Reference model: ceiling as a closed-form function of soft cycles
    bit     started = 0;
    int     m_st = 0;
    longint m_n = 0;
    bit     m_p1 = 0;
    longint m_c1 = 0, m_pi1 = 0;
    longint m_cmd = OUT_MIN, m_aw = 0;
    bit     m_sat = 0, m_vld = 0;
    longint cc, nc, d;

    function automatic longint ceil_of(input longint n);
        longint v;
        v = OUT_MIN + longint'(SS_STEP) * (n / SS_DIV);
        return (v > OUT_MAX) ? OUT_MAX : v;
    endfunction

    function automatic longint sat_l(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    always @(posedge i_CLK) begin
        if (i_RST || !i_EN) begin
            if (i_RST) started = 1;
            m_st = 0; m_n = 0; m_p1 = 0;
            m_cmd = OUT_MIN; m_aw = 0; m_sat = 0; m_vld = 0;
        end else begin
            cc = (m_st == 0) ? OUT_MIN : (m_st == 2) ? OUT_MAX : ceil_of(m_n);
            m_vld = 0;
            if (m_p1) begin
                d = m_c1 - m_cmd;
                if (d > RATE_MAX) d = RATE_MAX;
                if (d < -RATE_MAX) d = -RATE_MAX;
                nc = m_cmd + d;
                m_aw = sat_l(m_pi1 - nc);
                m_cmd = nc;
                m_sat = (m_aw != 0);
                m_vld = 1;
            end
            m_p1 = (m_st != 0) && i_VALID;
            if (m_p1) begin
                m_pi1 = longint'(i_PI);
                m_c1 = (m_pi1 < OUT_MIN) ? OUT_MIN : (m_pi1 > cc) ? cc : m_pi1;
            end
            if (m_st == 0) begin
                m_st = 1; m_n = 0;
            end else if (m_st == 1) begin
                if (ceil_of(m_n) == OUT_MAX) m_st = 2;
                else m_n++;
            end
        end
    end

    always @(negedge i_CLK) begin
        if (started) begin
            nchk++;
            if (longint'(o_CMD) != m_cmd || longint'(o_AW) != m_aw ||
                o_VALID !== m_vld || o_SAT !== m_sat ||
                int'(o_STATE) != m_st) begin
                errs++;
                $display("FAIL model t=%0t: cmd=%0d/%0d aw=%0d/%0d vld=%0b/%0b sat=%0b/%0b st=%0d/%0d (got/exp)",
                         $time, o_CMD, m_cmd, o_AW, m_aw, o_VALID, m_vld,
                         o_SAT, m_sat, o_STATE, m_st);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic strobe(input logic signed [31:0] v);
        i_PI = v; i_VALID = 1'b1;
        cyc();
        i_VALID = 1'b0;
        cyc();
    endtask

    initial begin
        int n;
        i_RST = 1'b1; i_EN = 1'b1; i_VALID = 1'b1; i_PI = 2000;
        repeat (3) @(posedge i_CLK);
        #1;
        chk("rst_cmd", o_CMD, 0);
        chk("rst_aw", o_AW, 0);
        chk("rst_vld", o_VALID, 0);
        chk("rst_state", o_STATE, 0);
        i_RST = 1'b0;

        n = 0;
        while (o_STATE != 2'd2 && n < 600) begin
            cyc();
            n++;
        end
        chk("ramp_edges", n, 402);
        repeat (5) cyc();
        chk("ss_cmd", o_CMD, 1000);
        chk("ss_aw", o_AW, 1000);
        chk("ss_sat", o_SAT, 1);

        i_PI = 500; i_VALID = 1'b1;
        repeat (12) cyc();
        i_VALID = 1'b0;
        repeat (2) cyc();
        chk("pre_rate_cmd", o_CMD, 500);
        strobe(800);
        chk("rate_cmd", o_CMD, 550);
        chk("rate_aw", o_AW, 250);
        chk("rate_vld", o_VALID, 1);
        cyc();
        chk("rate_vld_pulse", o_VALID, 0);
        chk("rate_hold", o_CMD, 550);

        i_PI = 0; i_VALID = 1'b1;
        repeat (14) cyc();
        i_VALID = 1'b0;
        repeat (2) cyc();
        strobe(-5);
        chk("lo_cmd", o_CMD, 0);
        chk("lo_aw", o_AW, -5);
        chk("lo_sat", o_SAT, 1);
        strobe(30);
        chk("lo2_cmd", o_CMD, 30);
        chk("lo2_aw", o_AW, 0);
        chk("lo2_sat", o_SAT, 0);

        i_PI = 1000; i_VALID = 1'b1;
        repeat (25) cyc();
        i_VALID = 1'b0;
        repeat (2) cyc();
        strobe(32'sh8000_0000);
        chk("awsat_cmd", o_CMD, 950);
        chk("awsat_aw", o_AW, -64'sd2147483648);

        i_PI = 700; i_VALID = 1'b1;
        cyc();
        i_VALID = 1'b0; i_EN = 1'b0;
        cyc();
        chk("drop_vld", o_VALID, 0);
        chk("drop_cmd", o_CMD, 0);
        chk("drop_state", o_STATE, 0);
        cyc();
        chk("drop_vld2", o_VALID, 0);
        i_EN = 1'b1; i_PI = 2000; i_VALID = 1'b1;
        cyc();
        chk("reen_state", o_STATE, 1);
        repeat (8) cyc();
        chk("reen_cmd", o_CMD, 10);

        for (int k = 0; k < 6000; k++) begin
            i_RST   = ($urandom_range(0, 799) == 0);
            i_EN    = ($urandom_range(0, 699) != 0);
            i_VALID = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) i_PI = $urandom;
            else i_PI = $signed($urandom_range(0, 1400)) - 200;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/pi_out_limiter.md
# pi_out_limiter

Output-conditioning stage placed directly downstream of the PI controller in the hybrid control loop. It clamps the raw PI output to a configurable command range and rate-limits it per update. At enable it applies a soft-start ceiling ramp, then returns the saturation excess as the anti-windup signal that feeds the PI `aw` input. The conditioned command drives the converter modulation (phase/frequency command) stage.

## Interface
Parameters:
- `OUT_MIN`, default 0 — lower command bound (signed 32).
- `OUT_MAX`, default 1000 — upper command bound (signed 32); `OUT_MIN < OUT_MAX` required.
- `RATE_MAX`, default 50 — max |change| of `o_CMD` per accepted update; must be ≥ 1.
- `SS_STEP`, default 10 — soft-start ceiling increment; must be ≥ 1.
- `SS_DIV`, default 4 — cycles between ceiling increments; must be ≥ 1.

Ports:
- `i_CLK`  in  1 — single clock, all logic on rising edge.
- `i_RST`  in  1 — reset, synchronous, active-high.
- `i_EN`  in  1 — loop enable; low forces IDLE.
- `i_PI`  in  signed 32 — raw PI output.
- `i_VALID`  in  1 — one-cycle strobe qualifying `i_PI`; back-to-back strobes allowed.
- `o_CMD`  out  signed 32 — conditioned command.
- `o_AW`  out  signed 32 — anti-windup excess, `i_PI − o_CMD`.
- `o_VALID`  out  1 — one-cycle strobe when `o_CMD`/`o_AW` update.
- `o_SAT`  out  1 — high when the last update had `o_AW ≠ 0`.
- `o_STATE`  out  2 — 0 IDLE, 1 SOFT, 2 RUN.

## Operation
- **States:**
  - IDLE: `ceil = OUT_MIN`, `o_CMD = OUT_MIN`, `o_AW = 0`, `o_SAT = 0`; strobes ignored.
  - IDLE→SOFT: transition on `i_EN = 1`.
  - SOFT: a divider counts `SS_DIV` cycles; on terminal count, `ceil ← min(ceil + SS_STEP, OUT_MAX)`. When `ceil` reaches `OUT_MAX`, move to RUN the following cycle.
  - RUN: `ceil = OUT_MAX`.
  - Any state: `i_EN = 0` → IDLE next cycle.
- **Stage 1** (on `i_VALID` in SOFT/RUN): `c = clamp(i_PI, OUT_MIN, ceil)`, using the `ceil` value in that cycle. Register `c` and `i_PI`.
- **Stage 2:** `d = c − o_CMD`. Limit `d` to `[−RATE_MAX, +RATE_MAX]`, then `o_CMD ← o_CMD + d`. Compute `o_AW ← sat32(i_PI − new o_CMD)`, set `o_SAT ← (o_AW ≠ 0)`, and pulse `o_VALID`.
- **Arithmetic:** all differences use 33-bit signed intermediates. `o_AW` saturates to [−2^31, 2^31−1]. `o_CMD` always stays within [`OUT_MIN`, `OUT_MAX`].
- **Back-to-back strobes:** stage 2 always uses the most recently registered `o_CMD`, including one written in the immediately preceding cycle.
- **EN drop:**
  - Both pipeline stages are flushed; no `o_VALID` is issued for in-flight samples.
  - The next cycle shows IDLE values.
  - If `i_EN` rises again, soft-start restarts from `OUT_MIN`.
- **Reset:**
  - Dominates `i_EN` and `i_VALID`.
  - Outputs: `o_CMD = OUT_MIN`, `o_AW = 0`, `o_VALID = 0`, `o_SAT = 0`, `o_STATE = IDLE`.
  - Internal state cleared: ceiling, divider and pipeline.

## Timing
- Latency is 2 cycles: `i_VALID` at cycle t produces `o_VALID` at t+2, with `o_CMD`, `o_AW` and `o_SAT` valid in the same cycle.
- Throughput is one sample per cycle.
- All outputs are registered; there is no combinational path from input to output.
- `o_CMD`, `o_AW` and `o_SAT` hold their value between strobes.
- The soft-start ceiling updates every `SS_DIV` cycles, independent of `i_VALID`.
- Full ramp takes `ceil((OUT_MAX − OUT_MIN)/SS_STEP) × SS_DIV` cycles, plus 1 cycle for SOFT→RUN.
- `i_EN` deassertion at cycle t: IDLE outputs appear at t+1.

## Structure
- **Shared control package:**
  - the `state_t` encoding (IDLE/SOFT/RUN);
  - the width constant 32;
  - functions `sat32` (33→32 signed saturate) and `clamp32`.
- **Sub-module `ss_ramp`:** the divider plus ceiling register. It has enable and restart inputs and outputs `ceil` and `done`. The remainder (FSM, two-stage pipeline, rate limiter) stays in `pi_out_limiter`.

## Test plan
- Reset, defaults: assert `i_RST` for 3 cycles with `i_EN = 1` and `i_VALID = 1` → `o_CMD = 0`, `o_AW = 0`, `o_VALID = 0`, `o_STATE = 0`.
- Soft start: release reset, `i_EN = 1`, `i_PI = 2000` with `i_VALID` every cycle → `o_CMD` follows the ceiling (+10 every 4 cycles). `o_STATE` goes to 2 about 401 cycles after EN. Final `o_CMD = 1000`, `o_AW = 1000`, `o_SAT = 1`.
- Rate limit in RUN: with `o_CMD = 500`, single strobe `i_PI = 800` → at t+2, `o_CMD = 550`, `o_AW = 250`, `o_VALID` high for 1 cycle.
- Lower clamp: with `o_CMD = 0`, strobe `i_PI = −5` → `o_CMD = 0`, `o_AW = −5`, `o_SAT = 1`. Then strobe `i_PI = 30` → `o_CMD = 30`, `o_AW = 0`, `o_SAT = 0`.
- AW saturation: with `o_CMD = 1000`, strobe `i_PI = −2^31` → `o_CMD = 950`, `o_AW = −2^31`.
- EN drop mid-pipeline: strobe at t, `i_EN = 0` at t+1 → no `o_VALID` at t+2. `o_CMD = 0` and `o_STATE = 0` from t+2. Re-enable → ceiling restarts at 0.
